// File: rtl/add_seq_arb_pkg.sv
// Shared constants for the sequential multi-precision adder arbiter.
// Slice width, FSM state codes, port-id width, index-width helper.
package add_seq_pkg;

  localparam int SLICE_W = 16;
  localparam int ID_W    = 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Slice index width: clog2(words), never below one bit.
  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/add_seq_arb_sbit.sv
// Shared 16-bit ripple-carry adder slice.
// Ports: a, b, cin in; sum, cout out.
module sbit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic c;

  always_comb begin
    c   = cin;
    sum = '0;
    for (int i = 0; i < 16; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/add_seq_arb.sv
// Two-port round-robin front end feeding one sbit, LSB slice first.
// Ports: clk, rst, req0/req1 {valid, ready, a, b, cin}, rsp {valid, id, sum, cout}, busy.
module add_seq_arb
  import add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [SLICE_W*WORDS-1:0] req0_a,
  input  logic [SLICE_W*WORDS-1:0] req0_b,
  input  logic                     req0_cin,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [SLICE_W*WORDS-1:0] req1_a,
  input  logic [SLICE_W*WORDS-1:0] req1_b,
  input  logic                     req1_cin,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [SLICE_W*WORDS-1:0] rsp_sum,
  output logic                     rsp_cout,
  output logic                     busy
);

  localparam int W  = SLICE_W * WORDS;
  localparam int IW = idx_w(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ADD  = ST_ADD,
    DONE = ST_DONE
  } state_t;

  state_t state;

  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    sum_reg;
  logic [W-1:0]    sum_next;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [ID_W-1:0] id_reg;
  logic            last_grant;
  logic            gnt;
  logic            accept;
  logic [31:0]     base;

  logic [SLICE_W-1:0] sa;
  logic [SLICE_W-1:0] sb;
  logic [SLICE_W-1:0] ss;
  logic               sc;

  // Contention flips against the last winner; a lone requester wins.
  always_comb begin
    gnt = 1'b0;
    unique case (1'b1)
      req0_valid && req1_valid:  gnt = ~last_grant;
      req1_valid && !req0_valid: gnt = 1'b1;
      default:                   gnt = 1'b0;
    endcase
  end

  assign req0_ready = (state == IDLE) && req0_valid && !gnt;
  assign req1_ready = (state == IDLE) && req1_valid && gnt;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    base     = 32'(idx) * 32'(SLICE_W);
    sa       = a_reg[base +: SLICE_W];
    sb       = b_reg[base +: SLICE_W];
    sum_next = sum_reg;
    sum_next[base +: SLICE_W] = ss;
  end

  sbit u_sbit (
    .a    (sa),
    .b    (sb),
    .cin  (carry),
    .sum  (ss),
    .cout (sc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      sum_reg    <= '0;
      idx        <= '0;
      carry      <= 1'b0;
      id_reg     <= '0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (accept) begin
            a_reg      <= gnt ? req1_a : req0_a;
            b_reg      <= gnt ? req1_b : req0_b;
            carry      <= gnt ? req1_cin : req0_cin;
            id_reg     <= gnt;
            last_grant <= gnt;
            sum_reg    <= '0;
            idx        <= '0;
            busy       <= 1'b1;
            state      <= ADD;
          end
        end
        ADD: begin
          sum_reg <= sum_next;
          carry   <= sc;
          if (idx == LAST) begin
            // Reset idx rather than wrap so it never points past the top slice.
            idx       <= '0;
            rsp_valid <= 1'b1;
            rsp_id    <= id_reg;
            rsp_sum   <= sum_next;
            rsp_cout  <= sc;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq_arb.sv
// Directed bench for add_seq_arb: WORDS=4 and WORDS=1 instances.
// Vector table for single ops, hand sequences for arbitration and reset.
module tb_add_seq_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v0, v1, rd0, rd1, c0, c1;
  logic [63:0] a0, b0, a1, b1;
  logic        rv, rid, rcout, bsy;
  logic [63:0] rsum;

  logic        u_v0, u_v1, u_rd0, u_rd1, u_c0, u_c1;
  logic [15:0] u_a0, u_b0, u_a1, u_b1;
  logic        u_rv, u_rid, u_rcout, u_bsy;
  logic [15:0] u_rsum;

  add_seq_arb #(.WORDS(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(rd0),
    .req0_a(a0), .req0_b(b0), .req0_cin(c0),
    .req1_valid(v1), .req1_ready(rd1),
    .req1_a(a1), .req1_b(b1), .req1_cin(c1),
    .rsp_valid(rv), .rsp_id(rid),
    .rsp_sum(rsum), .rsp_cout(rcout),
    .busy(bsy)
  );

  add_seq_arb #(.WORDS(1)) dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(u_v0), .req0_ready(u_rd0),
    .req0_a(u_a0), .req0_b(u_b0), .req0_cin(u_c0),
    .req1_valid(u_v1), .req1_ready(u_rd1),
    .req1_a(u_a1), .req1_b(u_b1), .req1_cin(u_c1),
    .rsp_valid(u_rv), .rsp_id(u_rid),
    .rsp_sum(u_rsum), .rsp_cout(u_rcout),
    .busy(u_bsy)
  );

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit          p;
    logic [63:0] a;
    logic [63:0] b;
    bit          cin;
    logic [63:0] s;
    bit          co;
  } vec_t;

  vec_t tv[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Sample the selected instance.
  task automatic smp(input bit d, output logic s_rv, output logic s_id,
                     output logic [63:0] s_sum, output logic s_co);
    if (d) begin
      s_rv = u_rv; s_id = u_rid; s_sum = {48'd0, u_rsum}; s_co = u_rcout;
    end else begin
      s_rv = rv; s_id = rid; s_sum = rsum; s_co = rcout;
    end
  endtask

  // Wait for the response strobe; lat counts cycles after the handshake edge.
  task automatic wait_rsp(input bit d, input string tag, output int lat,
                          output logic s_id, output logic [63:0] s_sum, output logic s_co);
    logic s_rv;
    lat = 0; s_id = 1'b0; s_sum = '0; s_co = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      smp(d, s_rv, s_id, s_sum, s_co);
      if (s_rv) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no rsp_valid expected strobe", tag);
    end
  endtask

  task automatic do_op(input bit d, input bit p, input logic [63:0] a,
                       input logic [63:0] b, input bit cin, input logic [63:0] es,
                       input bit ec, input int elat, input string tag);
    int w, lat;
    logic rdy, s_rv, s_id, s_co;
    logic [63:0] s_sum;
    @(negedge clk);
    if (d) begin
      u_v0 = 1'b1; u_a0 = a[15:0]; u_b0 = b[15:0]; u_c0 = cin;
    end else if (p) begin
      v1 = 1'b1; a1 = a; b1 = b; c1 = cin;
    end else begin
      v0 = 1'b1; a0 = a; b0 = b; c0 = cin;
    end
    #1;
    w = 0;
    rdy = d ? u_rd0 : (p ? rd1 : rd0);
    while (!rdy && w < 20) begin
      @(negedge clk);
      w++;
      rdy = d ? u_rd0 : (p ? rd1 : rd0);
    end
    chk({tag, "_ready"}, 64'(rdy), 64'd1);
    @(posedge clk);
    #1;
    u_v0 = 1'b0; v0 = 1'b0; v1 = 1'b0;
    wait_rsp(d, tag, lat, s_id, s_sum, s_co);
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_id"}, 64'(s_id), 64'(p));
    chk({tag, "_sum"}, s_sum, es);
    chk({tag, "_cout"}, 64'(s_co), 64'(ec));
    @(negedge clk);
    smp(d, s_rv, s_id, s_sum, s_co);
    chk({tag, "_strobe_len"}, 64'(s_rv), 64'd0);
    chk({tag, "_hold_sum"}, s_sum, es);
  endtask

  initial begin
    int lat, seen, t, last_t, bad;
    logic s_id, s_co;
    logic [63:0] s_sum;

    tv[0] = '{1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0};
    tv[1] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1};
    tv[2] = '{1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1};
    tv[3] = '{1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0,
              64'h2345_6789_ABCD_F001, 1'b0};
    tv[4] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    tv[5] = '{1'b1, 64'h0000_FFFF_0000_FFFF, 64'h1, 1'b1, 64'h0000_FFFF_0001_0001, 1'b0};

    v0 = 0; v1 = 0; c0 = 0; c1 = 0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    u_v0 = 0; u_v1 = 0; u_c0 = 0; u_c1 = 0;
    u_a0 = '0; u_b0 = '0; u_a1 = '0; u_b1 = '0;

    do_reset();
    #1;
    chk("rst_rsp_valid", 64'(rv), 64'd0);
    chk("rst_busy", 64'(bsy), 64'd0);
    chk("rst_rsp_sum", rsum, 64'd0);
    chk("rst_rsp_cout", 64'(rcout), 64'd0);
    chk("rst_rsp_id", 64'(rid), 64'd0);
    chk("rst_ready0_idle", 64'(rd0), 64'd0);
    chk("rst_w1_busy", 64'(u_bsy), 64'd0);
    chk("rst_w1_sum", 64'(u_rsum), 64'd0);

    for (int i = 0; i < 6; i++)
      do_op(1'b0, tv[i].p, tv[i].a, tv[i].b, tv[i].cin, tv[i].s, tv[i].co, 5,
            $sformatf("v%0d", i));

    // Both ports valid in the first cycle after reset.
    do_reset();
    v0 = 1; a0 = 64'd1; b0 = 64'd2; c0 = 0;
    v1 = 1; a1 = 64'd5; b1 = 64'd7; c1 = 0;
    #1;
    chk("both_rd0", 64'(rd0), 64'd1);
    chk("both_rd1", 64'(rd1), 64'd0);
    @(posedge clk);
    #1;
    v0 = 0;
    bad = 0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rd1) bad++;
      if (rv) begin
        lat = c;
        break;
      end
    end
    chk("both_first_lat", 64'(lat), 64'd5);
    chk("both_first_id", 64'(rid), 64'd0);
    chk("both_first_sum", rsum, 64'd3);
    chk("both_rd1_held_low", 64'(bad), 64'd0);
    @(negedge clk);
    chk("both_rd1_idle", 64'(rd1), 64'd1);
    @(posedge clk);
    #1;
    v1 = 0;
    wait_rsp(1'b0, "both_second", lat, s_id, s_sum, s_co);
    chk("both_second_lat", 64'(lat), 64'd5);
    chk("both_second_id", 64'(s_id), 64'd1);
    chk("both_second_sum", s_sum, 64'd12);

    // Fairness with both ports held valid.
    @(negedge clk);
    v0 = 1; a0 = 64'd100; b0 = 64'd23; c0 = 0;
    v1 = 1; a1 = 64'h10; b1 = 64'h20; c1 = 0;
    seen = 0; t = 0; last_t = 0;
    while (seen < 4 && t < 60) begin
      @(negedge clk);
      t++;
      if (rv) begin
        chk($sformatf("fair%0d_id", seen), 64'(rid), 64'(seen % 2));
        chk($sformatf("fair%0d_sum", seen), rsum, (seen % 2) ? 64'h30 : 64'd123);
        if (seen > 0) chk($sformatf("fair%0d_gap", seen), 64'(t - last_t), 64'd6);
        last_t = t;
        seen++;
        if (seen == 4) begin
          v0 = 0;
          v1 = 0;
        end
      end
    end
    v0 = 0; v1 = 0;
    chk("fair_count", 64'(seen), 64'd4);
    repeat (3) @(negedge clk);
    chk("fair_idle_busy", 64'(bsy), 64'd0);

    // Reset during the second ADD cycle aborts the operation.
    v0 = 1; a0 = 64'd3; b0 = 64'd4; c0 = 0;
    #1;
    chk("abort_ready", 64'(rd0), 64'd1);
    @(posedge clk);
    #1;
    v0 = 0;
    bad = 0;
    @(negedge clk);
    if (rv) bad++;
    @(negedge clk);
    if (rv) bad++;
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_busy", 64'(bsy), 64'd0);
    chk("abort_rsp_sum", rsum, 64'd0);
    chk("abort_rsp_id", 64'(rid), 64'd0);
    chk("abort_rsp_cout", 64'(rcout), 64'd0);
    for (int c = 0; c < 10; c++) begin
      if (rv) bad++;
      @(negedge clk);
    end
    chk("abort_no_rsp", 64'(bad), 64'd0);
    do_op(1'b0, 1'b1, 64'd5, 64'd7, 1'b0, 64'd12, 1'b0, 5, "abort_p1");

    // Single-slice instance.
    do_op(1'b1, 1'b0, 64'h1234, 64'h4321, 1'b1, 64'h5556, 1'b0, 2, "w1_a");
    do_op(1'b1, 1'b0, 64'hFFFF, 64'h0001, 1'b0, 64'h0000, 1'b1, 2, "w1_b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/add_seq_arb.md
Name: add_seq_arb

Overview:
Shares a single instance of the team's 16-bit ripple adder (sbit) between two requesters. Each requester submits a multi-precision add of WORDS×16 bits. The block arbitrates round-robin and feeds the adder one 16-bit slice per cycle, LSB first, with the carry registered between slices. It then returns the full sum and carry-out with a one-cycle response strobe. It sits between software-visible operand registers and the shared adder datapath.

Parameters:
WORDS, 4, number of 16-bit slices per operation (1..16); operand width is 16*WORDS.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
req0_valid  in  1  port 0 request
req0_ready  out  1  port 0 accept (combinational)
req0_a  in  16*WORDS  port 0 operand A
req0_b  in  16*WORDS  port 0 operand B
req0_cin  in  1  port 0 carry-in
req1_valid / req1_ready / req1_a / req1_b / req1_cin  same as port 0, for port 1
rsp_valid  out  1  one-cycle result strobe
rsp_id  out  1  port that owns the result
rsp_sum  out  16*WORDS  result
rsp_cout  out  1  final carry-out
busy  out  1  high in ADD and DONE

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high, and sampled on the rising edge.
- Reset values:
  - state=IDLE, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, busy=0.
  - Round-robin pointer last_grant=1, so port 0 wins first.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - grant is combinational. If only one port is valid, that port is granted. If both are valid, grant = ~last_grant.
  - reqN_ready = (state==IDLE) && reqN_valid && grant==N. The ready of the non-granted port is 0.
  - On valid&&ready:
    - Capture a, b, cin and the port id into internal registers.
    - Set idx=0, carry=cin, last_grant=N.
    - Go to ADD.
  - With no valid request, stay in IDLE.
- ADD:
  - Adder inputs: a_reg[idx*16 +:16], b_reg[idx*16 +:16], carry.
  - Each cycle: sum_reg slice idx <= adder sum; carry <= adder cout; idx++.
  - After the slice idx==WORDS-1 is processed, go to DONE.
  - Exactly WORDS cycles are spent in ADD.
- DONE:
  - rsp_valid=1 for exactly this cycle. rsp_id, rsp_sum and rsp_cout are valid in this cycle.
  - Next state: IDLE.
- Output hold: rsp_sum, rsp_cout and rsp_id hold their values until the next DONE or a reset. rsp_valid is 0 outside DONE.
- Latency: handshake on edge k gives ADD on cycles k+1..k+WORDS and rsp_valid on cycle k+WORDS+1.
- Throughput: one operation per WORDS+2 cycles. No pipelining. There is no response back-pressure; the consumer must take the strobe.
- Arithmetic is modulo 2^(16*WORDS); overflow is reported only through rsp_cout.
- Boundary conditions:
  - Requests arriving while busy get ready=0 and must be held by the requester. Dropping valid before acceptance is legal; nothing is recorded.
  - A port's valid rising in the same cycle that the other port is accepted is not granted until the next IDLE.
  - Reset mid-ADD or during DONE aborts the operation. No rsp_valid is produced. The block is in IDLE on the next cycle with all outputs at reset values.
  - WORDS=1: one ADD cycle; latency 2.
  - idx must not overrun. Its counter width is clog2(WORDS), with a minimum of 1 bit.

Decomposition:
- Shared package add_seq_pkg:
  - SLICE_W=16.
  - State encodings IDLE/ADD/DONE as localparams.
  - Port-id width constant (1).
- Sub-modules:
  - One existing sbit instance is the only datapath sub-module.
  - The round-robin grant logic is small and stays inline. Factor it as rr_arb2 only if a third client is added.

Test Plan:
1. Single port 0, WORDS=4: a=0x0000_0000_0000_FFFF, b=0x1, cin=0, accepted at edge k -> rsp_valid at k+5, rsp_id=0, rsp_sum=0x0000_0000_0001_0000, rsp_cout=0.
2. Full carry ripple across slices: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> rsp_sum=0, rsp_cout=1. Also a=0x8000_0000_0000_0000, b=0x8000_0000_0000_0000, cin=0 -> rsp_sum=0, rsp_cout=1.
3. Both ports valid in the first cycle after reset, port 1: a=5, b=7 -> port 0 served first (rsp_id=0), then port 1 (rsp_id=1, sum=12). req1_ready stays 0 until the block returns to IDLE.
4. Fairness: both ports held valid for 4 operations -> grant order 0,1,0,1. rsp_valid is spaced exactly 6 cycles apart.
5. Reset asserted on the 2nd ADD cycle -> no rsp_valid ever appears for that operation. Next cycle: busy=0, rsp_sum=0. A new port-1 request is then accepted normally.
6. WORDS=1: a=0x1234, b=0x4321, cin=1 -> rsp_sum=0x5556, rsp_cout=0, rsp_valid 2 cycles after the handshake. Second case: a=0xFFFF, b=0x0001, cin=0 -> rsp_sum=0x0000, rsp_cout=1.
